mux_feed_arbiter: RTL and testbench
===================================

Name: mux_feed_arbiter

Overview:
Upstream feeder for the registered 4-bit 2:1 mux stage. It accepts two independent 4-bit producer channels (A and B) over valid/ready handshakes and buffers each in a small FIFO. A round-robin arbiter drains the FIFOs and drives the mux's a, b and sel inputs: the newly popped word goes on the selected lane, and the other lane holds its value. The downstream mux registers y one clock later.

Parameters:
- WIDTH, 4, data width of each channel and of each output lane.
- DEPTH, 4, entries per channel FIFO; must be a power of 2 and at least 2.
- CW, log2(DEPTH)+1, width of the occupancy counters.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- a_data  input  WIDTH  channel A write data.
- a_valid  input  1  channel A write request.
- a_ready  output  1  channel A can accept a word.
- b_data  input  WIDTH  channel B write data.
- b_valid  input  1  channel B write request.
- b_ready  output  1  channel B can accept a word.
- stall  input  1  when 1, inhibits pops.
- a_out  output  WIDTH  registered lane-A value; drives mux a.
- b_out  output  WIDTH  registered lane-B value; drives mux b.
- sel_out  output  1  registered select; 0 = lane A, 1 = lane B; drives mux sel.
- out_valid  output  1  one-cycle pulse marking a new word on the selected lane.
- a_count  output  CW  channel A FIFO occupancy.
- b_count  output  CW  channel B FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state (rst_n low takes effect immediately, not at an edge):
  - FIFO pointers and counts go to 0; stored contents are discarded.
  - a_out = 0, b_out = 0, sel_out = 0, out_valid = 0.
  - last_grant = B, so A wins the first contention.
  - a_ready and b_ready are forced to 0 while rst_n is low.
- Ready: x_ready = rst_n & (x_count != DEPTH). It is combinational from state only and does not depend on x_valid or on a same-cycle pop.
- Push: a word is written on a posedge where x_valid & x_ready. A full FIFO does not accept a push even in a cycle where it pops; there is no pass-through.
- Pop eligibility: a FIFO is eligible if x_count != 0 and stall = 0. There is no fall-through, so a word pushed at edge k is poppable at edge k+1 at the earliest.
- Arbitration, evaluated at each posedge from pre-edge state:
  - Both eligible: grant the channel opposite last_grant.
  - One eligible: grant that channel.
  - Neither eligible: no grant.
  - last_grant updates to the granted channel; it holds when nothing is granted.
- Grant to A: a_out <= FIFO A head, sel_out <= 0, out_valid <= 1; b_out holds.
- Grant to B: b_out <= FIFO B head, sel_out <= 1, out_valid <= 1; a_out holds.
- No grant: a_out, b_out and sel_out hold; out_valid <= 0.
- At most one pop per cycle across both channels. Pushes to both channels in the same cycle are independent.
- Counts: x_count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop. It never exceeds DEPTH or goes below 0.
- Pointers: log2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0. FIFO order is strictly preserved across wrap.
- Latency: push at edge k gives the word on a_out/b_out after edge k+1 at the earliest; mux y follows after edge k+2.
- Throughput: one output word per cycle while either FIFO is non-empty and stall = 0.
- stall: freezes the arbiter and pops; pushes continue until full. A stall asserted in the same cycle as an eligible pop blocks that pop.
- Values written while x_ready = 0 are ignored; the producer must hold valid.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with a_valid = 1 → a_out = b_out = 0, sel_out = 0, out_valid = 0, counts 0, a_ready = b_ready = 0; after release, both ready = 1.
- Single word: push A = 4'b0010 at edge 1, stall = 0 → after edge 2: a_out = 0010, sel_out = 0, out_valid = 1, b_out = 0; after edge 3: out_valid = 0, outputs hold.
- Round-robin: with stall = 1, load A = {1, 2} and B = {7, 8}, then release stall → output sequence (lane, value, sel) is A1/0, B7/1, A2/0, B8/1 on consecutive cycles; the unselected lane holds its last value.
- Full and backpressure: with stall = 1, keep a_valid = 1 for 6 cycles with data 1..6 → a_count = 4, a_ready = 0, words 5 and 6 not accepted while the producer holds them; release stall → pops 1, 2, 3, 4 in order, then word 5 is accepted once a_ready = 1.
- Wrap-around streaming: B idle, push A = 0..9 on consecutive cycles with stall = 0 → a_out = 0..9 in order one cycle behind, out_valid high for 10 consecutive cycles, a_count ≤ 1 throughout.
- Mid-operation reset: with a_count = 3 and b_count = 2, drop rst_n midway between edges → counts, a_out, b_out, sel_out and out_valid go to 0 before the next edge; after release, the first push to A and B together grants A first.

Source files
------------

// File: rtl/mux_feed_arbiter_if.sv
// Bundles the two producer channels, the stall control and the registered mux-drive outputs.
// master = producer/controller side, slave = mux_feed_arbiter.
interface mux_feed_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic             stall;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             sel_out;
  logic             out_valid;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  modport master (
    output a_data, a_valid, b_data, b_valid, stall,
    input  a_ready, b_ready, a_out, b_out, sel_out, out_valid, a_count, b_count
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, stall,
    output a_ready, b_ready, a_out, b_out, sel_out, out_valid, a_count, b_count
  );
endinterface

// File: rtl/mux_feed_arbiter.sv
// Two-channel FIFO feeder for a registered 2:1 mux: buffers producers A and B and
// round-robin drains them onto the mux a/b/sel inputs, one word per cycle.
module mux_feed_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic            clk,
  input logic            rst_n,
  mux_feed_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // Channel 0 = A, channel 1 = B.
  logic [WIDTH-1:0] ch_data  [2];
  logic [WIDTH-1:0] ch_head  [2];
  logic [CW-1:0]    ch_count [2];
  logic [1:0]       ch_valid;
  logic [1:0]       ch_ready;
  logic [1:0]       ch_elig;
  logic [1:0]       ch_pop;

  assign ch_data[0]  = bus.a_data;
  assign ch_data[1]  = bus.b_data;
  assign ch_valid[0] = bus.a_valid;
  assign ch_valid[1] = bus.b_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic             push;

      // Ready looks only at stored occupancy: a full FIFO refuses a push even while popping.
      assign ch_ready[gi] = rst_n & (count_q != CW'(DEPTH));
      assign push         = ch_valid[gi] & ch_ready[gi];
      assign ch_elig[gi]  = (count_q != '0) & ~bus.stall;
      assign ch_head[gi]  = mem[rd_ptr_q];
      assign ch_count[gi] = count_q;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)       wr_ptr_d = wr_ptr_q + 1'b1;
        if (ch_pop[gi]) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, ch_pop[gi]})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage needs no reset; the pointers and count make old contents unreachable.
      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= ch_data[gi];
      end
    end
  endgenerate

  grant_e           last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic             grant_a, grant_b;

  always_comb begin
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;
    sel_d        = sel_q;
    out_valid_d  = 1'b0;
    last_grant_d = last_grant_q;
    // A wins contention unless it was the most recent grantee.
    grant_a = ch_elig[0] & (~ch_elig[1] | (last_grant_q == GRANT_B));
    grant_b = ch_elig[1] & ~grant_a;
    ch_pop  = {grant_b, grant_a};
    if (grant_a) begin
      a_out_d      = ch_head[0];
      sel_d        = 1'b0;
      out_valid_d  = 1'b1;
      last_grant_d = GRANT_A;
    end else if (grant_b) begin
      b_out_d      = ch_head[1];
      sel_d        = 1'b1;
      out_valid_d  = 1'b1;
      last_grant_d = GRANT_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q      <= '0;
      b_out_q      <= '0;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      last_grant_q <= GRANT_B;
    end else begin
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.a_ready   = ch_ready[0];
  assign bus.b_ready   = ch_ready[1];
  assign bus.a_count   = ch_count[0];
  assign bus.b_count   = ch_count[1];
  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.sel_out   = sel_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_feed_arbiter.sv
// Scoreboard bench for mux_feed_arbiter: a queue-based reference model predicts each output word,
// a negedge monitor pops and compares whenever out_valid is seen.
`timescale 1ns/1ps
module tb_mux_feed_arbiter;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mux_feed_arbiter_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  mux_feed_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  bit               last_b = 1'b1;
  logic [WIDTH-1:0] cur_a = '0, cur_b = '0;
  logic [WIDTH-1:0] mon_a = '0, mon_b = '0;
  logic             mon_sel = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    sb.delete();
    last_b  = 1'b1;
    cur_a   = '0;
    cur_b   = '0;
    mon_a   = '0;
    mon_b   = '0;
    mon_sel = 1'b0;
  endtask

  // Reference: two bounded queues, fair alternation under contention, pre-edge decisions.
  task automatic model_step();
    bit   ra, rb, ea, eb, ga, gb;
    exp_t e;
    if (!rst_n) return;
    ra = (qa.size() != DEPTH);
    rb = (qb.size() != DEPTH);
    ea = (qa.size() > 0) && !bus.stall;
    eb = (qb.size() > 0) && !bus.stall;
    ga = 1'b0;
    gb = 1'b0;
    if (ea && eb) begin
      if (last_b) ga = 1'b1; else gb = 1'b1;
    end else if (ea) ga = 1'b1;
    else if (eb) gb = 1'b1;
    e.sel = 1'b0;
    if (ga) begin cur_a = qa.pop_front(); e.sel = 1'b0; last_b = 1'b0; end
    if (gb) begin cur_b = qb.pop_front(); e.sel = 1'b1; last_b = 1'b1; end
    if (ga || gb) begin
      e.a = cur_a;
      e.b = cur_b;
      sb.push_back(e);
    end
    if (bus.a_valid && ra) qa.push_back(bus.a_data);
    if (bus.b_valid && rb) qb.push_back(bus.b_data);
  endtask

  task automatic post_check();
    check("a_count", int'(bus.a_count), qa.size());
    check("b_count", int'(bus.b_count), qb.size());
    check("a_ready", int'(bus.a_ready), (rst_n && qa.size() != DEPTH) ? 1 : 0);
    check("b_ready", int'(bus.b_ready), (rst_n && qb.size() != DEPTH) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    post_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got out_valid=1, expected no word (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("a_out", int'(bus.a_out), int'(e.a));
          check("b_out", int'(bus.b_out), int'(e.b));
          check("sel_out", int'(bus.sel_out), int'(e.sel));
          mon_a   = e.a;
          mon_b   = e.b;
          mon_sel = e.sel;
        end
      end else begin
        check("pending_output", sb.size(), 0);
        check("hold_a_out", int'(bus.a_out), int'(mon_a));
        check("hold_b_out", int'(bus.b_out), int'(mon_b));
        check("hold_sel_out", int'(bus.sel_out), int'(mon_sel));
      end
    end
  end

  initial begin
    int w;
    bit rdy;
    int rr_val [4];
    int rr_sel [4];
    rr_val = '{1, 7, 2, 8};
    rr_sel = '{0, 1, 0, 1};

    bus.a_data  = '0;
    bus.a_valid = 1'b1;
    bus.b_data  = '0;
    bus.b_valid = 1'b0;
    bus.stall   = 1'b0;

    // Reset held for two cycles with a producer pushing.
    tick();
    tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_a_out", int'(bus.a_out), 0);
    check("rst_sel_out", int'(bus.sel_out), 0);
    rst_n = 1'b1;
    bus.a_valid = 1'b0;
    #1;
    check("rel_a_ready", int'(bus.a_ready), 1);
    check("rel_b_ready", int'(bus.b_ready), 1);

    // Single word.
    bus.a_data  = 4'd2;
    bus.a_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0;
    tick();
    check("single_a_out", int'(bus.a_out), 2);
    check("single_valid", int'(bus.out_valid), 1);
    tick();
    check("single_valid_drop", int'(bus.out_valid), 0);

    // Round-robin from a fresh reset.
    do_reset();
    bus.stall   = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = 4'd1;
    bus.b_data  = 4'd7;
    tick();
    bus.a_data  = 4'd2;
    bus.b_data  = 4'd8;
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.stall   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_sel", int'(bus.sel_out), rr_sel[i]);
      check("rr_val", rr_sel[i] ? int'(bus.b_out) : int'(bus.a_out), rr_val[i]);
    end
    tick();

    // Full FIFO and backpressure with a producer that holds each word until accepted.
    bus.stall   = 1'b1;
    bus.a_valid = 1'b1;
    w = 1;
    for (int i = 0; i < 6; i++) begin
      bus.a_data = 4'(w);
      rdy = bus.a_ready;
      tick();
      if (rdy) w++;
    end
    check("full_a_count", int'(bus.a_count), 4);
    check("full_a_ready", int'(bus.a_ready), 0);
    check("full_next_word", w, 5);
    bus.stall = 1'b0;
    for (int i = 0; i < 20 && w < 7; i++) begin
      bus.a_data = 4'(w);
      rdy = bus.a_ready;
      tick();
      if (rdy) w++;
    end
    check("full_drained_words", w, 7);
    bus.a_valid = 1'b0;
    repeat (4) tick();

    // Pointer wrap-around streaming on A.
    for (int i = 0; i < 10; i++) begin
      bus.a_valid = 1'b1;
      bus.a_data  = 4'(i);
      tick();
      check("stream_count_le1", (bus.a_count <= 1) ? 1 : 0, 1);
    end
    bus.a_valid = 1'b0;
    repeat (2) tick();

    // Mid-operation asynchronous reset.
    bus.stall   = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = 4'd3;
    bus.b_data  = 4'd4;
    repeat (2) tick();
    bus.b_valid = 1'b0;
    tick();
    bus.a_valid = 1'b0;
    check("mid_a_count", int'(bus.a_count), 3);
    check("mid_b_count", int'(bus.b_count), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_a_count", int'(bus.a_count), 0);
    check("async_b_count", int'(bus.b_count), 0);
    check("async_a_out", int'(bus.a_out), 0);
    check("async_b_out", int'(bus.b_out), 0);
    check("async_valid", int'(bus.out_valid), 0);
    model_reset();
    tick();
    rst_n       = 1'b1;
    bus.stall   = 1'b0;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = 4'd9;
    bus.b_data  = 4'd5;
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();
    check("post_rst_first_sel", int'(bus.sel_out), 0);
    check("post_rst_first_a", int'(bus.a_out), 9);
    tick();
    check("post_rst_second_sel", int'(bus.sel_out), 1);
    check("post_rst_second_b", int'(bus.b_out), 5);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.a_data  = 4'($urandom_range(0, 15));
      bus.b_data  = 4'($urandom_range(0, 15));
      bus.stall   = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.stall   = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
